// File: rtl/vscale_fetch_queue_pkg.sv
// Shared constants for the vscale fetch front end: word size, bubble/NOP
// encodings and the halt marker instruction.
package vscale_fetch_queue_pkg;

    localparam int          XPR_LEN           = 32;
    localparam logic [31:0] RV_NOP            = 32'h0000_0013;
    // "jal x0, 0" (jump to self) doubles as the halt marker.
    localparam logic [31:0] RV32_HALT         = 32'h0000_006f;
    localparam logic [31:0] BUBBLE_PC_DEFAULT = 32'd120;

endpackage

// File: rtl/vscale_sync_fifo.sv
// Single-clock FIFO with synchronous flush; head entry is read straight from
// the storage registers so it is visible the cycle after it was written.
module vscale_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       enq,
    input  logic [WIDTH-1:0]           enq_data,
    input  logic                       deq,
    output logic [WIDTH-1:0]           deq_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_deq_s;

    // Pointer/occupancy bookkeeping and storage write.
    always_comb begin
        mem_d    = mem_q;
        do_deq_s = deq & (count_q != '0);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                mem_d[wr_ptr_q] = enq_data;
            end else begin
                mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
            end
            wr_ptr_d = wr_ptr_q + AW'(enq);
            rd_ptr_d = rd_ptr_q + AW'(do_deq_s);
            count_d  = count_q + CW'(enq) - CW'(do_deq_s);
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign deq_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);

endmodule

// File: rtl/vscale_fetch_queue.sv
// Instruction-fetch front end: one outstanding in-order imem request, a
// DEPTH-entry decoupling queue toward DX, redirect flush and sticky halt.
module vscale_fetch_queue
    import vscale_fetch_queue_pkg::*;
#(
    parameter int               XLEN            = XPR_LEN,
    parameter int               DEPTH           = 4,
    parameter int               CORE_IDX_WIDTH  = 2,
    parameter int               RESET_PC_BASE   = 4,
    parameter int               RESET_PC_STRIDE = 20,
    parameter logic [XLEN-1:0]  BUBBLE_PC       = XLEN'(BUBBLE_PC_DEFAULT),
    parameter logic [XLEN-1:0]  NOP_INST        = XLEN'(RV_NOP),
    parameter logic [XLEN-1:0]  HALT_INST       = XLEN'(RV32_HALT)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CORE_IDX_WIDTH-1:0]   core_id,
    output logic                        imem_req,
    output logic [XLEN-1:0]             imem_addr,
    input  logic                        imem_wait,
    input  logic [XLEN-1:0]             imem_rdata,
    input  logic                        imem_badmem_e,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_pc,
    input  logic                        deq_ready,
    output logic                        deq_valid,
    output logic [XLEN-1:0]             deq_pc,
    output logic [XLEN-1:0]             deq_inst,
    output logic                        deq_badmem,
    output logic                        halted,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = 2 * XLEN + 1;

    logic            pending_q, pending_d;
    logic            discard_q, discard_d;
    logic            halted_q, halted_d;
    logic [XLEN-1:0] pending_addr_q, pending_addr_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

    logic [XLEN-1:0] reset_pc_s;
    logic [XLEN-1:0] req_addr_s;
    logic            resp_s, resp_live_s, halt_hit_s, credit_ok_s;
    logic            issue_s, enq_s, pop_s, show_s;
    logic [FW-1:0]   head_s;
    logic [CW-1:0]   fifo_count_s;
    logic            fifo_full_s, fifo_empty_s;

    assign reset_pc_s = XLEN'(RESET_PC_BASE) + XLEN'(core_id) * XLEN'(RESET_PC_STRIDE);

    // Issue/response decisions. A redirect overrides halt and the credit
    // check because the queue is flushed in the same cycle.
    always_comb begin
        req_addr_s  = redirect_valid ? redirect_pc : fetch_pc_q;
        resp_s      = pending_q & ~imem_wait;
        resp_live_s = resp_s & ~discard_q & ~halted_q & ~redirect_valid;
        halt_hit_s  = resp_live_s & (imem_rdata == HALT_INST);
        enq_s       = resp_live_s & ~halt_hit_s & ~fifo_full_s;
        pop_s       = ~fifo_empty_s & deq_ready & ~redirect_valid;
        credit_ok_s = ({1'b0, fifo_count_s} + (CW+1)'(pending_q)) < (CW+1)'(DEPTH);
        issue_s     = ~reset & (~pending_q | ~imem_wait)
                    & (redirect_valid | (~halted_q & ~halt_hit_s & credit_ok_s));
    end

    // Next-state for the pending request, fetch PC and halt flag.
    always_comb begin
        pending_d      = pending_q;
        discard_d      = discard_q;
        pending_addr_d = pending_addr_q;
        fetch_pc_d     = fetch_pc_q;
        if (issue_s) begin
            pending_d      = 1'b1;
            discard_d      = 1'b0;
            pending_addr_d = req_addr_s;
            fetch_pc_d     = req_addr_s + XLEN'(3'd4);
        end else if (redirect_valid) begin
            // Only reachable while the old request is still waiting.
            discard_d  = 1'b1;
            fetch_pc_d = redirect_pc;
        end else if (resp_s) begin
            pending_d = 1'b0;
            discard_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        if (redirect_valid) begin
            halted_d = 1'b0;
        end else if (halt_hit_s) begin
            halted_d = 1'b1;
        end else begin
            halted_d = halted_q;
        end
    end

    // Fetch control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q      <= 1'b0;
            discard_q      <= 1'b0;
            halted_q       <= 1'b0;
            pending_addr_q <= '0;
            fetch_pc_q     <= reset_pc_s;
        end else begin
            pending_q      <= pending_d;
            discard_q      <= discard_d;
            halted_q       <= halted_d;
            pending_addr_q <= pending_addr_d;
            fetch_pc_q     <= fetch_pc_d;
        end
    end

    vscale_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .enq      (enq_s),
        .enq_data ({pending_addr_q, imem_rdata, imem_badmem_e}),
        .deq      (pop_s),
        .deq_data (head_s),
        .count    (fifo_count_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s)
    );

    assign show_s     = ~fifo_empty_s & ~reset;
    assign imem_req   = issue_s;
    assign imem_addr  = reset ? '0 : req_addr_s;
    assign deq_valid  = show_s;
    assign deq_pc     = show_s ? head_s[FW-1 -: XLEN] : BUBBLE_PC;
    assign deq_inst   = show_s ? head_s[XLEN:1] : NOP_INST;
    assign deq_badmem = show_s & head_s[0];
    assign halted     = halted_q;
    assign count      = fifo_count_s;

endmodule

// File: tb/tb_vscale_fetch_queue.sv
// Directed self-checking bench for vscale_fetch_queue with a one-deep
// imem model whose data word is 0xA0000000 | address.
module tb_vscale_fetch_queue;
    import vscale_fetch_queue_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  core_id;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_wait;
    logic [31:0] imem_rdata;
    logic        imem_badmem_e;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_inst;
    logic        deq_badmem;
    logic        halted;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem_addr_r;
    logic [31:0] halt_addr;
    logic [31:0] bad_addr;

    vscale_fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .core_id        (core_id),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_wait      (imem_wait),
        .imem_rdata     (imem_rdata),
        .imem_badmem_e  (imem_badmem_e),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .deq_ready      (deq_ready),
        .deq_valid      (deq_valid),
        .deq_pc         (deq_pc),
        .deq_inst       (deq_inst),
        .deq_badmem     (deq_badmem),
        .halted         (halted),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_req) mem_addr_r <= imem_addr;
    end
    assign imem_rdata    = (mem_addr_r == halt_addr) ? RV32_HALT : (32'hA000_0000 | mem_addr_r);
    assign imem_badmem_e = (mem_addr_r == bad_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] id);
        reset   = 1'b1;
        core_id = id;
        next_cycle();
        next_cycle();
        reset   = 1'b0;
    endtask

    // Occupancy may never exceed DEPTH (an enqueue at full would push it over).
    always @(negedge clk) begin
        if (reset === 1'b0) chk("count_bound", {31'd0, (count <= 3'd4)}, 32'd1);
    end

    initial begin
        reset = 1'b1; core_id = 2'd2; imem_wait = 1'b0; deq_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'd0;
        halt_addr = 32'hFFFF_FFFF; bad_addr = 32'hFFFF_FFFF;

        // Reset state and streaming at one fetch per cycle (core 2 -> PC 44)
        next_cycle(); next_cycle(); #1;
        chk("rst_deq_valid", {31'd0, deq_valid}, 32'd0);
        chk("rst_deq_pc", deq_pc, 32'd120);
        chk("rst_deq_inst", deq_inst, 32'h0000_0013);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        reset = 1'b0; #1;
        chk("c0_req", {31'd0, imem_req}, 32'd1);
        chk("c0_addr", imem_addr, 32'd44);
        next_cycle(); #1;
        chk("c1_valid", {31'd0, deq_valid}, 32'd0);
        next_cycle(); #1;
        chk("c2_valid", {31'd0, deq_valid}, 32'd1);
        chk("c2_pc", deq_pc, 32'd44);
        chk("c2_inst", deq_inst, 32'hA000_002C);
        next_cycle(); #1;
        chk("c3_pc", deq_pc, 32'd48);
        chk("c3_count", {29'd0, count}, 32'd1);
        next_cycle(); #1;
        chk("c4_pc", deq_pc, 32'd52);

        // Backpressure: queue fills to DEPTH, issue stops, release is contiguous
        next_cycle(); deq_ready = 1'b0;
        repeat (9) next_cycle();
        #1;
        chk("stall_count", {29'd0, count}, 32'd4);
        chk("stall_req", {31'd0, imem_req}, 32'd0);
        chk("stall_head", deq_pc, 32'd56);
        deq_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("drain_valid", {31'd0, deq_valid}, 32'd1);
            chk("drain_pc", deq_pc, 32'd56 + 32'(4 * i));
            next_cycle(); #1;
        end

        // imem_wait held 3 cycles on the response to 0x30; fault flag on 0x34
        bad_addr = 32'h34;
        do_reset(2'd2); #1;
        next_cycle(); #1;
        next_cycle(); imem_wait = 1'b1; #1;
        chk("wait_req0", {31'd0, imem_req}, 32'd0);
        chk("wait_head", deq_pc, 32'd44);
        next_cycle(); #1;
        chk("wait_valid", {31'd0, deq_valid}, 32'd0);
        chk("wait_bub_pc", deq_pc, 32'd120);
        chk("wait_bub_inst", deq_inst, 32'h0000_0013);
        chk("wait_count", {29'd0, count}, 32'd0);
        next_cycle(); #1;
        chk("wait_req2", {31'd0, imem_req}, 32'd0);
        next_cycle(); imem_wait = 1'b0; #1;
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'h34);
        chk("rel_count", {29'd0, count}, 32'd0);
        next_cycle(); #1;
        chk("rel_pc", deq_pc, 32'h30);
        chk("rel_inst", deq_inst, 32'hA000_0030);
        chk("rel_bad0", {31'd0, deq_badmem}, 32'd0);
        next_cycle(); #1;
        chk("bad_pc", deq_pc, 32'h34);
        chk("bad_flag", {31'd0, deq_badmem}, 32'd1);

        // Redirect while the request to 28 is waiting: discard it, refetch 0x200
        bad_addr = 32'hFFFF_FFFF;
        do_reset(2'd1); #1;
        next_cycle(); #1;
        next_cycle(); imem_wait = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
        chk("redir_req", {31'd0, imem_req}, 32'd0);
        chk("redir_head", deq_pc, 32'd24);
        next_cycle(); imem_wait = 1'b0; redirect_valid = 1'b0; #1;
        chk("redir_count", {29'd0, count}, 32'd0);
        chk("redir_valid", {31'd0, deq_valid}, 32'd0);
        chk("redir_req2", {31'd0, imem_req}, 32'd1);
        chk("redir_addr", imem_addr, 32'h200);
        next_cycle(); #1;
        chk("redir_discard", {31'd0, deq_valid}, 32'd0);
        next_cycle(); #1;
        chk("redir_pc", deq_pc, 32'h200);
        chk("redir_inst", deq_inst, 32'hA000_0200);

        // Halt fetched at 0x40, then resumed by a redirect to 0x100
        halt_addr = 32'h40;
        do_reset(2'd2); #1;
        repeat (5) next_cycle();
        #1;
        chk("halt_issue", imem_addr, 32'h40);
        next_cycle(); #1;
        chk("halt_req", {31'd0, imem_req}, 32'd0);
        chk("halt_prev", deq_pc, 32'h3C);
        next_cycle(); #1;
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_valid", {31'd0, deq_valid}, 32'd0);
        chk("halt_bub_pc", deq_pc, 32'd120);
        chk("halt_bub_inst", deq_inst, 32'h0000_0013);
        for (int i = 0; i < 4; i++) begin
            next_cycle(); #1;
            chk("halt_idle", {31'd0, imem_req}, 32'd0);
        end
        next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
        chk("resume_req", {31'd0, imem_req}, 32'd1);
        chk("resume_addr", imem_addr, 32'h100);
        next_cycle(); redirect_valid = 1'b0; #1;
        chk("resume_halted", {31'd0, halted}, 32'd0);
        chk("resume_addr2", imem_addr, 32'h104);
        next_cycle(); #1;
        chk("resume_pc", deq_pc, 32'h100);

        // Reset mid-stream with three entries queued (core 3 -> PC 64)
        halt_addr = 32'hFFFF_FFFF; deq_ready = 1'b0;
        do_reset(2'd3); #1;
        repeat (4) next_cycle();
        #1;
        chk("mid_count3", {29'd0, count}, 32'd3);
        chk("mid_head", deq_pc, 32'd64);
        reset = 1'b1; #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_valid", {31'd0, deq_valid}, 32'd0);
        next_cycle(); reset = 1'b0; core_id = 2'd0; #1;
        chk("mid_count0", {29'd0, count}, 32'd0);
        chk("mid_valid", {31'd0, deq_valid}, 32'd0);
        chk("mid_pc", deq_pc, 32'd120);
        chk("mid_req", {31'd0, imem_req}, 32'd1);
        chk("mid_addr", imem_addr, 32'd64);
        chk("mid_halted", {31'd0, halted}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
